// File: rtl/time_capture_writer.sv
// time_capture_writer
//
// Write-side engine for the time-domain display buffer. It watches a stream of
// 8-bit samples, arms on a level/slope trigger (or a timeout-forced trigger),
// writes one screen-width record into the sample RAM through port A, then holds
// until a frame sync so each displayed frame shows one coherent capture.
//
// Parameters:
//   cstSamples  samples per record, one per visible column (max 1024)
//   cstTimeout  valid samples waited while armed before a forced trigger
//               (0 disables the forced trigger)
//
// Ports:
//   ck100MHz     in   system clock, rising edge
//   rstN         in   asynchronous active-low reset
//   run          in   1 = keep capturing, 0 = stop after the current record
//   trigSlope    in   0 = rising, 1 = falling
//   trigLevel    in   [7:0] trigger threshold (unsigned)
//   sampleValid  in   one-cycle strobe qualifying sampleIn
//   sampleIn     in   [7:0] unsigned sample
//   frameSync    in   one-cycle pulse at start of vertical blank
//   decimFactor  in   [3:0] write one of every N samples in a record (0/1 = all)
//                     present only when TIME_CAPTURE_DECIM_EN is defined
//   enaTime      out  RAM port-A enable
//   weaTime      out  RAM port-A write enable
//   addraTime    out  [9:0] RAM port-A address
//   dinaTime     out  [7:0] RAM port-A data
//   busy         out  armed or capturing
//   captureDone  out  one-cycle pulse the cycle after the last write of a record
//   autoTrig     out  1 = last record started by timeout; updated at record start
//
// Optional feature macro: TIME_CAPTURE_DECIM_EN (capture decimation).

module time_capture_writer #(
  parameter int unsigned cstSamples = 640,
  parameter int unsigned cstTimeout = 4096
) (
  input  logic       ck100MHz,
  input  logic       rstN,
  input  logic       run,
  input  logic       trigSlope,
  input  logic [7:0] trigLevel,
  input  logic       sampleValid,
  input  logic [7:0] sampleIn,
  input  logic       frameSync,
`ifdef TIME_CAPTURE_DECIM_EN
  input  logic [3:0] decimFactor,
`endif
  output logic       enaTime,
  output logic       weaTime,
  output logic [9:0] addraTime,
  output logic [7:0] dinaTime,
  output logic       busy,
  output logic       captureDone,
  output logic       autoTrig
);

  // Timeout counter is at least one bit wide so cstTimeout = 0 still elaborates.
  localparam int unsigned TimeoutW    = (cstTimeout < 2) ? 1 : $clog2(cstTimeout + 1);
  localparam int unsigned TimeoutCntW = TimeoutW + 1;
  localparam logic [TimeoutCntW-1:0] TimeoutVal = TimeoutCntW'(cstTimeout);
  localparam logic [9:0] LastAddr = 10'(cstSamples - 1);

  // StDone is the cycle in which the last write is on the RAM port; captureDone
  // is registered out of it so the pulse lands one cycle after that write, and
  // frameSync arriving during that write cycle is deliberately not seen.
  typedef enum logic [2:0] {
    StIdle,
    StArmed,
    StCapture,
    StDone,
    StHold
  } state_e;

  state_e state_q, state_d;

  logic [7:0]          prev_sample_q, prev_sample_d;
  logic                prev_valid_q, prev_valid_d;
  logic [TimeoutW-1:0] tmo_cnt_q, tmo_cnt_d;
  logic [9:0]          sample_cnt_q, sample_cnt_d;
  logic                we_q, we_d;
  logic [9:0]          addr_q, addr_d;
  logic [7:0]          din_q, din_d;
  logic                done_q, done_d;
  logic                auto_trig_q, auto_trig_d;

  logic                   rise_hit;
  logic                   fall_hit;
  logic                   trig_real;
  logic                   trig_force;
  logic [TimeoutCntW-1:0] tmo_inc;
  logic                   tmo_sat;
  logic                   keep;

  // Trigger detection on the current sample against the previous valid one.
  always_comb begin
    rise_hit   = prev_valid_q && (prev_sample_q < trigLevel) && (sampleIn >= trigLevel);
    fall_hit   = prev_valid_q && (prev_sample_q > trigLevel) && (sampleIn <= trigLevel);
    trig_real  = trigSlope ? fall_hit : rise_hit;
    tmo_inc    = {1'b0, tmo_cnt_q} + TimeoutCntW'(1);
    tmo_sat    = &tmo_cnt_q;
    trig_force = (cstTimeout != 0) && (tmo_inc == TimeoutVal);
  end

`ifdef TIME_CAPTURE_DECIM_EN
  // dec_cnt counts valid samples since the last written one in a record.
  logic [3:0] dec_cnt_q, dec_cnt_d;

  always_comb begin
    if (decimFactor <= 4'd1) begin
      keep = 1'b1;
    end else begin
      keep = (dec_cnt_q == (decimFactor - 4'd1));
    end
  end

  always_comb begin
    dec_cnt_d = dec_cnt_q;
    if (state_q != StCapture) begin
      // The trigger sample is always written, so counting restarts there.
      dec_cnt_d = 4'd0;
    end else if (sampleValid) begin
      dec_cnt_d = keep ? 4'd0 : (dec_cnt_q + 4'd1);
    end
  end

  always_ff @(posedge ck100MHz or negedge rstN) begin
    if (!rstN) begin
      dec_cnt_q <= 4'd0;
    end else begin
      dec_cnt_q <= dec_cnt_d;
    end
  end
`else
  assign keep = 1'b1;
`endif

  always_comb begin
    state_d       = state_q;
    prev_sample_d = prev_sample_q;
    prev_valid_d  = prev_valid_q;
    tmo_cnt_d     = tmo_cnt_q;
    sample_cnt_d  = sample_cnt_q;
    we_d          = 1'b0;
    addr_d        = addr_q;
    din_d         = din_q;
    done_d        = 1'b0;
    auto_trig_d   = auto_trig_q;

    unique case (state_q)
      StIdle: begin
        prev_valid_d = 1'b0;
        tmo_cnt_d    = '0;
        if (run) begin
          state_d = StArmed;
        end
      end

      StArmed: begin
        if (!run) begin
          // Stop has priority over a trigger on the same cycle: nothing written.
          state_d = StIdle;
        end else if (sampleValid) begin
          prev_sample_d = sampleIn;
          prev_valid_d  = 1'b1;
          if (!tmo_sat) begin
            tmo_cnt_d = tmo_inc[TimeoutW-1:0];
          end
          if (trig_real || trig_force) begin
            we_d         = 1'b1;
            addr_d       = 10'd0;
            din_d        = sampleIn;
            sample_cnt_d = 10'd1;
            // A real trigger coinciding with the timeout counts as real.
            auto_trig_d  = !trig_real;
            prev_valid_d = 1'b0;
            tmo_cnt_d    = '0;
            state_d      = (LastAddr == 10'd0) ? StDone : StCapture;
          end
        end
      end

      StCapture: begin
        if (sampleValid && keep) begin
          we_d         = 1'b1;
          addr_d       = sample_cnt_q;
          din_d        = sampleIn;
          sample_cnt_d = sample_cnt_q + 10'd1;
          if (sample_cnt_q == LastAddr) begin
            state_d = StDone;
          end
        end
      end

      StDone: begin
        done_d  = 1'b1;
        state_d = StHold;
      end

      StHold: begin
        if (frameSync) begin
          state_d = run ? StArmed : StIdle;
        end
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge ck100MHz or negedge rstN) begin
    if (!rstN) begin
      state_q       <= StIdle;
      prev_sample_q <= 8'd0;
      prev_valid_q  <= 1'b0;
      tmo_cnt_q     <= '0;
      sample_cnt_q  <= 10'd0;
      we_q          <= 1'b0;
      addr_q        <= 10'd0;
      din_q         <= 8'd0;
      done_q        <= 1'b0;
      auto_trig_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      prev_sample_q <= prev_sample_d;
      prev_valid_q  <= prev_valid_d;
      tmo_cnt_q     <= tmo_cnt_d;
      sample_cnt_q  <= sample_cnt_d;
      we_q          <= we_d;
      addr_q        <= addr_d;
      din_q         <= din_d;
      done_q        <= done_d;
      auto_trig_q   <= auto_trig_d;
    end
  end

  assign enaTime     = we_q;
  assign weaTime     = we_q;
  assign addraTime   = addr_q;
  assign dinaTime    = din_q;
  assign captureDone = done_q;
  assign autoTrig    = auto_trig_q;
  // StDone still has the final write on the port, so it counts as capturing.
  assign busy        = (state_q == StArmed) || (state_q == StCapture) || (state_q == StDone);

endmodule

// File: tb/tb_time_capture_writer.sv
// Directed bench for time_capture_writer: auto trigger (and a second instance
// with the timeout disabled), rising and falling triggers, asynchronous reset
// mid-record, run control, and decimation when TIME_CAPTURE_DECIM_EN is set.

module tb_time_capture_writer;

  localparam int unsigned Samples = 640;

  logic       clk = 1'b0;
  logic       rstN;
  logic       run;
  logic       run0;
  logic       trigSlope;
  logic [7:0] trigLevel;
  logic       sampleValid;
  logic [7:0] sampleIn;
  logic       frameSync;
`ifdef TIME_CAPTURE_DECIM_EN
  logic [3:0] decim;
`endif

  logic       enaTime, weaTime, busy, captureDone, autoTrig;
  logic [9:0] addraTime;
  logic [7:0] dinaTime;
  logic       ena0, we0, busy0, done0, auto0;
  logic [9:0] addr0;
  logic [7:0] din0;

  always #5 clk = ~clk;

  time_capture_writer #(
    .cstSamples (Samples),
    .cstTimeout (1000)
  ) dut (
    .ck100MHz    (clk),
    .rstN        (rstN),
    .run         (run),
    .trigSlope   (trigSlope),
    .trigLevel   (trigLevel),
    .sampleValid (sampleValid),
    .sampleIn    (sampleIn),
    .frameSync   (frameSync),
`ifdef TIME_CAPTURE_DECIM_EN
    .decimFactor (decim),
`endif
    .enaTime     (enaTime),
    .weaTime     (weaTime),
    .addraTime   (addraTime),
    .dinaTime    (dinaTime),
    .busy        (busy),
    .captureDone (captureDone),
    .autoTrig    (autoTrig)
  );

  time_capture_writer #(
    .cstSamples (Samples),
    .cstTimeout (0)
  ) dut0 (
    .ck100MHz    (clk),
    .rstN        (rstN),
    .run         (run0),
    .trigSlope   (trigSlope),
    .trigLevel   (trigLevel),
    .sampleValid (sampleValid),
    .sampleIn    (sampleIn),
    .frameSync   (frameSync),
`ifdef TIME_CAPTURE_DECIM_EN
    .decimFactor (decim),
`endif
    .enaTime     (ena0),
    .weaTime     (we0),
    .addraTime   (addr0),
    .dinaTime    (din0),
    .busy        (busy0),
    .captureDone (done0),
    .autoTrig    (auto0)
  );

  int n_checks;
  int n_fail;
  int base;
  int done_base;
  int ok_base;

  // Write log, captured at each rising edge (values of the preceding cycle).
  logic [9:0] wa [4096];
  logic [7:0] wd [4096];
  int         wr_n    = 0;
  int         wr0_n   = 0;
  int         done_n  = 0;
  int         done_ok = 0;
  logic       prev_we = 1'b0;
  logic [9:0] prev_addr = 10'd0;

  always @(posedge clk) begin
    if (weaTime && enaTime) begin
      if (wr_n < 4096) begin
        wa[wr_n] <= addraTime;
        wd[wr_n] <= dinaTime;
      end
      wr_n <= wr_n + 1;
    end
    if (captureDone) begin
      done_n <= done_n + 1;
      if (prev_we && (prev_addr == 10'(Samples - 1))) done_ok <= done_ok + 1;
    end
    prev_we   <= weaTime;
    prev_addr <= addraTime;
    if (we0) wr0_n <= wr0_n + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic pulse_sync();
    sampleValid = 1'b0;
    frameSync   = 1'b1;
    @(negedge clk);
    frameSync   = 1'b0;
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rstN = 1'b0; run = 1'b0; run0 = 1'b0; trigSlope = 1'b0; trigLevel = 8'd128;
    sampleValid = 1'b0; sampleIn = 8'd0; frameSync = 1'b0;
`ifdef TIME_CAPTURE_DECIM_EN
    decim = 4'd0;
`endif
    repeat (2) @(negedge clk);

    // Reset state
    chk("rst_outputs", 32'({enaTime, weaTime, addraTime, dinaTime, busy, captureDone, autoTrig}),
        0);
    rstN = 1'b1;
    @(negedge clk);
    chk("idle_busy", 32'(busy), 0);

    // Auto trigger on a flat signal: 1000th valid sample after arming
    run  = 1'b1;
    run0 = 1'b1;
    @(negedge clk);
    chk("auto_armed_busy", 32'(busy), 1);
    base = wr_n; done_base = done_n; ok_base = done_ok;
    for (int i = 1; i <= 1000 + Samples + 5; i++) begin
      sampleValid = 1'b1;
      sampleIn    = 8'd50;
      @(negedge clk);
      if (i == 999) chk("auto_no_early_we", 32'(weaTime), 0);
      if (i == 1000) begin
        chk("auto_none_before", wr_n - base, 0);
        chk("auto_we", 32'({enaTime, weaTime}), 3);
        chk("auto_addr", 32'(addraTime), 0);
        chk("auto_din", 32'(dinaTime), 50);
        chk("auto_flag", 32'(autoTrig), 1);
      end
    end
    chk("auto_count", wr_n - base, Samples);
    chk("auto_last_addr", 32'(wa[base + Samples - 1]), Samples - 1);
    chk("auto_done", done_n - done_base, 1);
    chk("auto_done_timing", done_ok - ok_base, 1);
    chk("auto_hold_busy", 32'(busy), 0);
    chk("tmo0_no_writes", wr0_n, 0);
    chk("tmo0_still_armed", 32'(busy0), 1);
    chk("tmo0_outputs", 32'({ena0, we0, addr0, din0, done0, auto0}), 0);
    run0 = 1'b0;
    pulse_sync();
    chk("sync_rearm_busy", 32'(busy), 1);

    // Rising trigger on a repeating ramp
    base = wr_n; done_base = done_n; ok_base = done_ok;
    for (int i = 0; i < 128 + Samples + 20; i++) begin
      sampleValid = 1'b1;
      sampleIn    = 8'(i);
      @(negedge clk);
      if (i == 127) chk("rise_no_early_we", 32'(weaTime), 0);
      if (i == 128) begin
        chk("rise_we", 32'({enaTime, weaTime}), 3);
        chk("rise_first", 32'({addraTime, dinaTime}), 32'({10'd0, 8'd128}));
        chk("rise_autotrig", 32'(autoTrig), 0);
      end
      if (i == 129) chk("rise_second", 32'({addraTime, dinaTime}), 32'({10'd1, 8'd129}));
    end
    chk("rise_count", wr_n - base, Samples);
    for (int k = 0; k < int'(Samples); k++) begin
      chk("rise_record", 32'({wa[base + k], wd[base + k]}), 32'({10'(k), 8'(128 + k)}));
    end
    chk("rise_done", done_n - done_base, 1);
    chk("rise_done_timing", done_ok - ok_base, 1);
    chk("rise_hold_ena", 32'(enaTime), 0);
    pulse_sync();

    // Falling trigger; then asynchronous reset while writing address 300
    trigSlope = 1'b1;
    trigLevel = 8'd100;
    base = wr_n;
    sampleValid = 1'b1;
    sampleIn    = 8'd100;
    @(negedge clk);
    chk("fall_first_no_trig", 32'(weaTime), 0);
    for (int i = 0; i <= 455; i++) begin
      sampleValid = 1'b1;
      sampleIn    = 8'(255 - i);
      @(negedge clk);
      if (i == 154) chk("fall_no_early_we", 32'(weaTime), 0);
      if (i == 155) chk("fall_first", 32'({addraTime, dinaTime}), 32'({10'd0, 8'd100}));
    end
    chk("fall_at_300", 32'({addraTime, dinaTime}), 32'({10'd300, 8'd56}));
    chk("fall_count_300", wr_n - base, 300);
    chk("fall_second", 32'({wa[base + 1], wd[base + 1]}), 32'({10'd1, 8'd99}));
    rstN = 1'b0;
    #1;
    chk("rst_mid_outputs",
        32'({enaTime, weaTime, addraTime, dinaTime, busy, captureDone, autoTrig}), 0);
    @(negedge clk);
    rstN        = 1'b1;
    sampleValid = 1'b0;
    trigSlope   = 1'b0;
    trigLevel   = 8'd128;
    @(negedge clk);

    // Restart at address 0; run dropped at address 200 still completes the record
    base = wr_n; done_base = done_n; ok_base = done_ok;
    for (int i = 0; i < 128 + Samples + 20; i++) begin
      sampleValid = 1'b1;
      sampleIn    = 8'(i);
      @(negedge clk);
      if (i == 128) chk("restart_first", 32'({addraTime, dinaTime}), 32'({10'd0, 8'd128}));
      if (i == 328) begin
        chk("drop_at_200", 32'(addraTime), 200);
        run = 1'b0;
      end
    end
    chk("drop_count", wr_n - base, Samples);
    chk("drop_last", 32'({wa[base + Samples - 1], wd[base + Samples - 1]}),
        32'({10'd639, 8'd255}));
    chk("drop_done", done_n - done_base, 1);
    chk("drop_done_timing", done_ok - ok_base, 1);
    pulse_sync();
    chk("drop_idle_busy", 32'(busy), 0);

    // Run raised then dropped while armed: back to idle, nothing written
    run = 1'b1;
    @(negedge clk);
    chk("armed_busy", 32'(busy), 1);
    run = 1'b0;
    base = wr_n;
    for (int i = 120; i < 140; i++) begin
      sampleValid = 1'b1;
      sampleIn    = 8'(i);
      @(negedge clk);
      if (i == 120) chk("armed_drop_busy", 32'(busy), 0);
    end
    sampleValid = 1'b0;
    repeat (2) @(negedge clk);
    chk("armed_drop_writes", wr_n - base, 0);

`ifdef TIME_CAPTURE_DECIM_EN
    // Decimation by 4 from the trigger sample
    decim = 4'd4;
    run   = 1'b1;
    @(negedge clk);
    base = wr_n;
    for (int i = 0; i < 128 + 4 * (Samples - 1) + 20; i++) begin
      sampleValid = 1'b1;
      sampleIn    = 8'(i);
      @(negedge clk);
    end
    chk("decim_count", wr_n - base, Samples);
    for (int k = 0; k < int'(Samples); k++) begin
      chk("decim_record", 32'({wa[base + k], wd[base + k]}), 32'({10'(k), 8'(128 + 4 * k)}));
    end
    sampleValid = 1'b0;
    decim = 4'd0;
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/time_capture_writer.md
Name: time_capture_writer

Overview:
- Write-side engine for the time-domain display buffer: it fills the 640-point sample RAM that the video-side image controller reads on port B.
- Accepts a stream of 8-bit audio samples and arms on a level/slope trigger (oscilloscope style).
- Writes exactly one screen-width record through the RAM port-A signals (enaTime/weaTime/addraTime/dinaTime).
- Re-arms only after a frame sync, so each displayed frame shows one coherent capture.

Parameters:
- cstSamples, 640: samples per capture (one per visible column); max 1024.
- cstTimeout, 4096: valid samples waited in ARMED before a forced (auto) trigger; 0 disables auto-trigger.

Ports:
- ck100MHz  in  1  system clock, all logic on rising edge
- rstN  in  1  asynchronous active-low reset
- run  in  1  level; 1 = keep capturing, 0 = stop after current record
- trigSlope  in  1  0 = rising, 1 = falling
- trigLevel  in  8  trigger threshold (unsigned)
- sampleValid  in  1  one-cycle strobe qualifying sampleIn
- sampleIn  in  8  unsigned sample
- frameSync  in  1  one-cycle pulse at start of vertical blank
- enaTime  out  1  RAM port-A enable
- weaTime  out  1  RAM port-A write enable
- addraTime  out  10  RAM port-A address
- dinaTime  out  8  RAM port-A data
- busy  out  1  high in ARMED or CAPTURE
- captureDone  out  1  one-cycle pulse after last write of a record
- autoTrig  out  1  1 = last record started by timeout, 0 = real trigger; updated at record start

Behaviour:
- Reset (rstN low, any time, asynchronous): state IDLE; all outputs 0; prevSample, timeout counter, sample counter cleared. No partial-record recovery; the next record restarts at address 0.
- State IDLE:
  - run=1 -> ARMED next cycle.
  - prev-valid flag cleared.
- State ARMED:
  - On each sampleValid, compare the current sample with prevSample, then store prevSample <= sampleIn.
  - Rising trigger: prev-valid && prevSample < trigLevel && sampleIn >= trigLevel.
  - Falling trigger: prev-valid && prevSample > trigLevel && sampleIn <= trigLevel.
  - The first valid sample after entering ARMED cannot trigger.
  - Timeout counter increments per valid sample. If cstTimeout != 0 and the counter would reach cstTimeout on this sample, force a trigger.
  - On trigger, go to CAPTURE:
    - the triggering sample is written at address 0, so sample counter = 1;
    - autoTrig <= forced.
  - A real trigger and a timeout on the same sample count as a real trigger (autoTrig=0).
  - run=0 in ARMED -> IDLE next cycle; nothing written.
- State CAPTURE:
  - Each sampleValid is written at address = sample counter; the counter then increments.
  - The write of sample k = cstSamples-1 is the last one. The cycle after it, pulse captureDone and go to HOLD.
  - run=0 during CAPTURE is ignored until the record completes.
- State HOLD:
  - Samples are ignored.
  - On frameSync: run=1 -> ARMED; run=0 -> IDLE.
  - frameSync in the same cycle the last write occurs is not seen; wait for the next one.
- Write timing:
  - Every RAM write is registered. weaTime=enaTime=1 for exactly one cycle, the cycle after the accepted sampleValid.
  - addraTime/dinaTime are valid in that cycle. When no write occurs, addraTime and dinaTime hold their last values and weaTime=enaTime=0.
  - Latency: sampleValid -> write = 1 cycle; last write -> captureDone = 1 cycle.
- Back-to-back sampleValid (every cycle) must be sustained with no drops.
- Addresses never exceed cstSamples-1; there is no wrap within a record.
- Counters:
  - sample counter 10 bits;
  - timeout counter wide enough for cstTimeout; it saturates, never wraps.
  - All comparisons are unsigned 8-bit.

Optional Feature:
- Macro: TIME_CAPTURE_DECIM_EN.
- With the macro defined:
  - extra input decimFactor [3:0]; 0 or 1 = no decimation.
  - In CAPTURE only, one of every decimFactor valid samples is written, counting from the trigger sample, which is always written.
  - Triggering and timeout still evaluate every valid sample.
- Without the macro: the port is absent and every valid sample in CAPTURE is written.

Test Plan:
- Reset: rstN low mid-CAPTURE at address 300 -> all outputs 0 within the same cycle; after release with run=1, the next record starts at address 0.
- Rising trigger: ramp 0..255 repeating, one valid per cycle, trigLevel=128, trigSlope=0 -> first write addr 0 data 128, then data 129.., 640 writes at addr 0..639, captureDone one cycle after addr 639, autoTrig=0, then no writes until frameSync.
- Falling trigger: ramp 255..0, trigLevel=100, trigSlope=1 -> first write addr 0 data 100; first sample after arming equal to 100 does not trigger.
- Auto trigger: constant 50, cstTimeout=1000 -> the 1000th valid sample after arming is written at addr 0, autoTrig=1; with cstTimeout=0, no writes ever.
- Run control: run dropped at addr 200 -> record completes to 639, captureDone, then after frameSync go to IDLE, busy=0; run dropped in ARMED -> IDLE next cycle, zero writes.
- Decimation (macro on): decimFactor=4, ramp with step 1 triggering at 128 -> writes data 128, 132, 136..; 640 writes total.
